// File: rtl/oled_pkg.sv
// Shared definitions for the PMOD OLED link: word width, receiver state encoding
// and the SSD1331 command bytes the benches drive.
package oled_pkg;

    localparam int WORD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    localparam logic [7:0] DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] REMAP       = 8'hA0;
    localparam logic [7:0] MASTER_CFG  = 8'hAD;
    localparam logic [7:0] CONTRAST_A  = 8'h81;

endpackage

// File: rtl/oled_pin_sync.sv
// Brings the asynchronous OLED pins into the system clock domain and detects
// SCK rising and CS falling/rising edges on the synchronised copies.
module oled_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    input  logic dc,
    input  logic res,
    output logic cs_sync,
    output logic mosi_sync,
    output logic dc_sync,
    output logic res_sync,
    output logic sck_rise,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] dc_q;
    logic [SYNC_STAGES-1:0] res_q;
    logic                   sck_prev;
    logic                   cs_prev;

    // CS and RES reset to their inactive (high) level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= '1;
            sck_q    <= '0;
            mosi_q   <= '0;
            dc_q     <= '0;
            res_q    <= '1;
            sck_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            cs_q     <= {cs_q[SYNC_STAGES-2:0], cs};
            sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
            dc_q     <= {dc_q[SYNC_STAGES-2:0], dc};
            res_q    <= {res_q[SYNC_STAGES-2:0], res};
            sck_prev <= sck_q[SYNC_STAGES-1];
            cs_prev  <= cs_q[SYNC_STAGES-1];
        end
    end

    assign cs_sync   = cs_q[SYNC_STAGES-1];
    assign mosi_sync = mosi_q[SYNC_STAGES-1];
    assign dc_sync   = dc_q[SYNC_STAGES-1];
    assign res_sync  = res_q[SYNC_STAGES-1];
    assign sck_rise  = sck_q[SYNC_STAGES-1] & ~sck_prev;
    assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_prev;
    assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_prev;

endmodule

// File: rtl/oled_spi_receiver.sv
// SSD1331-side SPI mode-0 receiver: oversampled pins, MSB-first deserialiser,
// DC-tagged words on a valid/ready output with overrun and frame-error flags.
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int N           = WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_CS,
    input  logic             i_SCK,
    input  logic             i_MOSI,
    input  logic             i_DC,
    input  logic             i_RES,
    input  logic             i_READY,
    output logic [N-1:0]     o_DATA,
    output logic             o_DC,
    output logic             o_VALID,
    output logic             o_OVERRUN,
    output logic             o_FRAME_ERR,
    output logic [CNT_W-1:0] o_BYTE_CNT,
    output logic             o_BUSY
);

    localparam int             BCW      = $clog2(N + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);

    logic cs_sync, mosi_sync, dc_sync, res_sync;
    logic sck_rise, cs_fall, cs_rise;

    rx_state_t      state;
    logic [BCW-1:0] bit_cnt;
    logic [N-1:0]   shift;
    logic [N-1:0]   shift_next;

    oled_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk      (i_CLK),
        .rst_n    (i_RST_N),
        .cs       (i_CS),
        .sck      (i_SCK),
        .mosi     (i_MOSI),
        .dc       (i_DC),
        .res      (i_RES),
        .cs_sync  (cs_sync),
        .mosi_sync(mosi_sync),
        .dc_sync  (dc_sync),
        .res_sync (res_sync),
        .sck_rise (sck_rise),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    // The completed word is taken from shift_next so o_VALID rises in the same
    // cycle as the last shift, one edge after the synchronised SCK rise.
    assign shift_next = {shift[N-2:0], mosi_sync};
    assign o_BUSY     = ~cs_sync;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            o_DATA      <= '0;
            o_DC        <= 1'b0;
            o_VALID     <= 1'b0;
            o_OVERRUN   <= 1'b0;
            o_FRAME_ERR <= 1'b0;
            o_BYTE_CNT  <= '0;
        end else begin
            o_FRAME_ERR <= 1'b0;
            if (!res_sync) begin
                // Display reset drops the pending word and any partial frame but keeps statistics.
                state   <= ST_IDLE;
                bit_cnt <= '0;
                shift   <= '0;
                o_VALID <= 1'b0;
            end else begin
                if (o_VALID && i_READY) begin
                    o_VALID <= 1'b0;
                end
                unique case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        if (cs_fall) begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        // CS release wins over a coincident SCK rise.
                        if (cs_rise) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            shift   <= '0;
                            if (bit_cnt != '0) begin
                                o_FRAME_ERR <= 1'b1;
                            end
                        end else if (sck_rise) begin
                            shift <= shift_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                if (!o_VALID || i_READY) begin
                                    o_DATA     <= shift_next;
                                    o_DC       <= dc_sync;
                                    o_VALID    <= 1'b1;
                                    o_BYTE_CNT <= o_BYTE_CNT + CNT_W'(1);
                                end else begin
                                    o_OVERRUN <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BCW'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Bench for oled_spi_receiver: table of CS frames, hand sequences for
// backpressure / display reset / async reset, and a randomised word stream.
module tb_oled_spi_receiver;

    logic        clk;
    logic        i_RST_N, i_CS, i_SCK, i_MOSI, i_DC, i_RES, i_READY;
    logic [7:0]  o_DATA;
    logic        o_DC, o_VALID, o_OVERRUN, o_FRAME_ERR, o_BUSY;
    logic [15:0] o_BYTE_CNT;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_word;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic [8:0] prev_word  = '0;
    logic       prev_fe    = 1'b0;
    int         vcyc       = 0;
    int         fe_cyc     = 0;
    int         fe_pulses  = 0;
    bit         rand_ready = 1'b0;

    oled_spi_receiver #(.N(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .i_CLK      (clk),
        .i_RST_N    (i_RST_N),
        .i_CS       (i_CS),
        .i_SCK      (i_SCK),
        .i_MOSI     (i_MOSI),
        .i_DC       (i_DC),
        .i_RES      (i_RES),
        .i_READY    (i_READY),
        .o_DATA     (o_DATA),
        .o_DC       (o_DC),
        .o_VALID    (o_VALID),
        .o_OVERRUN  (o_OVERRUN),
        .o_FRAME_ERR(o_FRAME_ERR),
        .o_BYTE_CNT (o_BYTE_CNT),
        .o_BUSY     (o_BUSY)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cs_low();
        i_CS = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        i_CS = 1'b1;
        wait_clk(6);
    endtask

    // One SCK period is 20 system clocks; MOSI/DC change while SCK is low.
    task automatic send_bits(input logic [7:0] d, input logic dcv, input int nbits, input bit lat);
        for (int i = 0; i < nbits; i++) begin
            i_MOSI = d[7-i];
            i_DC   = dcv;
            wait_clk(10);
            i_SCK = 1'b1;
            if (lat && i == nbits - 1) begin
                repeat (2) @(posedge clk);
                #1;
                check("latency_early", 32'(o_VALID), 32'd0);
                @(posedge clk);
                #1;
                check("latency_valid", 32'(o_VALID), 32'd1);
                check("latency_data", 32'(o_DATA), 32'(d));
                check("latency_dc", 32'(o_DC), 32'(dcv));
                #1;
                wait_clk(7);
            end else begin
                wait_clk(10);
            end
            i_SCK = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic dcv);
        exp_q.push_back({dcv, d});
        send_bits(d, dcv, 8, 1'b0);
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (i_RST_N) begin
            if (o_VALID && i_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got %0h expected none", {o_DC, o_DATA});
                end else begin
                    mon_word = exp_q.pop_front();
                    check("word", 32'({o_DC, o_DATA}), 32'(mon_word));
                end
            end
            if (prev_valid && !prev_acc && o_VALID)
                check("data_stable", 32'({o_DC, o_DATA}), 32'(prev_word));
            if (o_VALID) vcyc++;
            if (o_FRAME_ERR) fe_cyc++;
            if (o_FRAME_ERR && !prev_fe) fe_pulses++;
        end
        prev_valid = o_VALID;
        prev_acc   = o_VALID && i_READY;
        prev_word  = {o_DC, o_DATA};
        prev_fe    = o_FRAME_ERR;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) i_READY = 1'($urandom_range(0, 1));
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         nbits;
        int         exp_words;
        int         exp_fe;
    } frame_vec_t;

    frame_vec_t vecs[7];

    initial begin
        int cnt0, vc0, fe0, fp0, nw;
        logic [7:0] d;
        logic dcv;

        vecs[0] = '{8'hAF, 1'b0, 8, 1, 0};
        vecs[1] = '{8'hB7, 1'b1, 5, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, 8, 1, 0};
        vecs[3] = '{8'h80, 1'b0, 1, 0, 1};
        vecs[4] = '{8'hFE, 1'b1, 7, 0, 1};
        vecs[5] = '{8'h00, 1'b0, 0, 0, 0};
        vecs[6] = '{8'hAE, 1'b0, 8, 1, 0};

        // reset
        i_RST_N = 1'b0;
        i_CS    = 1'b1;
        i_SCK   = 1'b0;
        i_MOSI  = 1'b0;
        i_DC    = 1'b0;
        i_RES   = 1'b1;
        i_READY = 1'b0;
        wait_clk(3);
        check("rst_data", 32'(o_DATA), 32'd0);
        check("rst_valid", 32'(o_VALID), 32'd0);
        check("rst_cnt", 32'(o_BYTE_CNT), 32'd0);
        check("rst_flags", 32'({o_DC, o_OVERRUN, o_FRAME_ERR, o_BUSY}), 32'd0);
        i_RST_N = 1'b1;
        wait_clk(5);

        // single command with latency check
        i_READY = 1'b1;
        vc0 = vcyc; fe0 = fe_cyc;
        cs_low();
        check("busy_low_cs", 32'(o_BUSY), 32'd1);
        exp_q.push_back({1'b0, DISP_ON()});
        send_bits(8'hAF, 1'b0, 8, 1'b1);
        cs_high();
        check("busy_high_cs", 32'(o_BUSY), 32'd0);
        check("t1_cnt", 32'(o_BYTE_CNT), 32'd1);
        check("t1_valid_cycles", 32'(vcyc - vc0), 32'd1);
        check("t1_no_fe", 32'(fe_cyc - fe0), 32'd0);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // randomised stream with random backpressure
        cnt0 = int'(o_BYTE_CNT); fp0 = fe_pulses; nw = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            cs_low();
            for (int w = 0, n = $urandom_range(1, 4); w < n; w++) begin
                d   = 8'($urandom);
                dcv = 1'($urandom);
                send_word(d, dcv);
                nw++;
            end
            cs_high();
        end
        rand_ready = 1'b0;
        wait_clk(1);
        i_READY = 1'b1;
        wait_clk(10);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_cnt", 32'(int'(o_BYTE_CNT) - cnt0), 32'(nw));
        check("rand_overrun", 32'(o_OVERRUN), 32'd0);
        check("rand_no_fe", 32'(fe_pulses - fp0), 32'd0);

        // table of single frames, including truncated ones
        for (int v = 0; v < 7; v++) begin
            cnt0 = int'(o_BYTE_CNT); fe0 = fe_cyc; fp0 = fe_pulses;
            if (vecs[v].nbits == 8) exp_q.push_back({vecs[v].dc, vecs[v].data});
            cs_low();
            send_bits(vecs[v].data, vecs[v].dc, vecs[v].nbits, 1'b0);
            cs_high();
            wait_clk(4);
            check("vec_cnt", 32'(int'(o_BYTE_CNT) - cnt0), 32'(vecs[v].exp_words));
            check("vec_fe_cycles", 32'(fe_cyc - fe0), 32'(vecs[v].exp_fe));
            check("vec_fe_pulses", 32'(fe_pulses - fp0), 32'(vecs[v].exp_fe));
            check("vec_drained", 32'(exp_q.size()), 32'd0);
        end

        // burst under one CS
        cnt0 = int'(o_BYTE_CNT);
        cs_low();
        send_word(8'hA0, 1'b0);
        send_word(8'h72, 1'b1);
        cs_high();
        check("burst_cnt", 32'(int'(o_BYTE_CNT) - cnt0), 32'd2);
        check("burst_drained", 32'(exp_q.size()), 32'd0);

        // backpressure and overrun
        i_READY = 1'b0;
        cnt0 = int'(o_BYTE_CNT);
        cs_low();
        exp_q.push_back({1'b0, 8'h81});
        send_bits(8'h81, 1'b0, 8, 1'b0);
        send_bits(8'h55, 1'b1, 8, 1'b0);
        wait_clk(4);
        check("bp_data", 32'({o_DC, o_DATA}), 32'({1'b0, 8'h81}));
        check("bp_valid", 32'(o_VALID), 32'd1);
        check("bp_overrun", 32'(o_OVERRUN), 32'd1);
        check("bp_cnt", 32'(int'(o_BYTE_CNT) - cnt0), 32'd1);
        i_READY = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 32'(o_VALID), 32'd0);
        check("bp_overrun_sticky", 32'(o_OVERRUN), 32'd1);
        #1;
        cs_high();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // display reset mid-word with a word pending
        i_READY = 1'b0;
        fp0 = fe_pulses;
        cs_low();
        exp_q.push_back({1'b1, 8'h3C});
        send_bits(8'h3C, 1'b1, 8, 1'b0);
        cnt0 = int'(o_BYTE_CNT);
        send_bits(8'hE0, 1'b1, 3, 1'b0);
        i_RES = 1'b0;
        wait_clk(6);
        check("res_valid", 32'(o_VALID), 32'd0);
        check("res_cnt", 32'(o_BYTE_CNT), 32'(cnt0));
        check("res_overrun_held", 32'(o_OVERRUN), 32'd1);
        void'(exp_q.pop_back());
        i_CS = 1'b1;
        wait_clk(6);
        i_RES = 1'b1;
        wait_clk(6);
        check("res_no_fe", 32'(fe_pulses - fp0), 32'd0);
        i_READY = 1'b1;
        cs_low();
        send_word(8'hAE, 1'b0);
        cs_high();
        check("res_cnt_after", 32'(int'(o_BYTE_CNT) - cnt0), 32'd1);
        check("res_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset between clock edges, mid-byte
        i_READY = 1'b0;
        cs_low();
        send_word(8'h5A, 1'b1);
        send_bits(8'hC0, 1'b0, 2, 1'b0);
        @(posedge clk);
        #3;
        i_RST_N = 1'b0;
        #1;
        check("arst_data", 32'(o_DATA), 32'd0);
        check("arst_valid", 32'(o_VALID), 32'd0);
        check("arst_cnt", 32'(o_BYTE_CNT), 32'd0);
        check("arst_flags", 32'({o_DC, o_OVERRUN, o_FRAME_ERR, o_BUSY}), 32'd0);
        exp_q.delete();
        i_CS = 1'b1;
        i_SCK = 1'b0;
        wait_clk(3);
        i_RST_N = 1'b1;
        wait_clk(5);
        i_READY = 1'b1;
        cs_low();
        send_word(8'hAF, 1'b0);
        cs_high();
        check("arst_cnt_after", 32'(o_BYTE_CNT), 32'd1);
        check("arst_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [7:0] DISP_ON();
        return 8'hAF;
    endfunction

endmodule
